icache_refill: RTL and testbench

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/icache_refill.sv | 154 +++++++++++++++
 tb/tb_icache_refill.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// I-cache line refill engine: one AXI-style burst per miss, beats to data RAM, then tag.
// Define ICACHE_REFILL_CWF_EN for critical-word-first (WRAP burst from the missing beat).
`timescale 1ns/1ps
module icache_refill #(
   parameter int IDX_W  = 8,
   parameter int BEAT_W = 2,
   localparam int TAG_W = 32-IDX_W-BEAT_W-3
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    miss_valid_i,
   input  logic [31:0]             miss_addr_i,
   output logic                    miss_ready_o,
   output logic                    mem_ar_valid_o,
   input  logic                    mem_ar_ready_i,
   output logic [31:0]             mem_ar_addr_o,
   output logic [7:0]              mem_ar_len_o,
   output logic [1:0]              mem_ar_burst_o,
   input  logic                    mem_r_valid_i,
   output logic                    mem_r_ready_o,
   input  logic [63:0]             mem_r_data_i,
   input  logic [1:0]              mem_r_resp_i,
   input  logic                    mem_r_last_i,
   output logic [IDX_W+BEAT_W-1:0] ram_addr_o,
   output logic [63:0]             ram_data_o,
   output logic                    ram_wr_o,
   output logic                    tag_wr_o,
   output logic [IDX_W-1:0]        tag_index_o,
   output logic [TAG_W-1:0]        tag_o,
   output logic                    tag_valid_o,
   output logic                    refill_done_o,
   output logic                    refill_err_o
);

   localparam int OFF_W  = BEAT_W+3;
   localparam int LINE_W = 32-OFF_W;
   localparam int NB     = 1 << BEAT_W;

   typedef enum logic [1:0] {IDLE, REQ, FILL, TAG} state_t;

   state_t                  state_q, state_d;
   logic [LINE_W-1:0]       line_q;
   logic [BEAT_W-1:0]       beat_q;
   logic [BEAT_W-1:0]       cnt_q;
   logic                    err_q;
   logic                    ram_wr_q;
   logic [IDX_W+BEAT_W-1:0] ram_addr_q;
   logic [63:0]             ram_data_q;

   logic                    accept;
   logic                    beat_acc;
   logic                    last_beat;
   logic                    beat_bad;
   logic [BEAT_W-1:0]       start_beat;
   logic [31:0]             ar_addr;
   logic [IDX_W-1:0]        idx;
   logic                    unused_addr;

`ifdef ICACHE_REFILL_CWF_EN
   localparam logic [1:0] BURST = 2'b10;
   assign start_beat = miss_addr_i[3 +: BEAT_W];
   // beat_q still holds the start beat while in REQ
   assign ar_addr    = {line_q, beat_q, 3'b000};
`else
   localparam logic [1:0] BURST = 2'b01;
   assign start_beat = '0;
   assign ar_addr    = {line_q, {OFF_W{1'b0}}};
`endif

   assign unused_addr = ^miss_addr_i[OFF_W-1:0];
   assign idx       = line_q[IDX_W-1:0];
   assign accept    = miss_valid_i && (state_q == IDLE);
   assign beat_acc  = mem_r_valid_i && (state_q == FILL);
   assign last_beat = (cnt_q == {BEAT_W{1'b1}});
   assign beat_bad  = (mem_r_resp_i != 2'b00) || (mem_r_last_i != last_beat);

   assign ram_wr_o   = ram_wr_q;
   assign ram_addr_o = ram_addr_q;
   assign ram_data_o = ram_data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         line_q     <= '0;
         beat_q     <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         ram_wr_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
      end else begin
         state_q  <= state_d;
         ram_wr_q <= beat_acc;
         if (accept) begin
            line_q <= miss_addr_i[31:OFF_W];
            beat_q <= start_beat;
            cnt_q  <= '0;
            err_q  <= 1'b0;
         end
         if (beat_acc) begin
            ram_addr_q <= {idx, beat_q};
            ram_data_q <= mem_r_data_i;
            beat_q     <= beat_q + 1'b1;
            cnt_q      <= cnt_q + 1'b1;
            if (beat_bad) err_q <= 1'b1;
         end
         if (state_q == TAG) err_q <= 1'b0;
      end
   end

   always_comb begin
      state_d        = state_q;
      miss_ready_o   = 1'b0;
      mem_ar_valid_o = 1'b0;
      mem_ar_addr_o  = '0;
      mem_ar_len_o   = '0;
      mem_ar_burst_o = '0;
      mem_r_ready_o  = 1'b0;
      tag_wr_o       = 1'b0;
      tag_index_o    = '0;
      tag_o          = '0;
      tag_valid_o    = 1'b0;
      refill_done_o  = 1'b0;
      refill_err_o   = 1'b0;
      unique case (state_q)
         IDLE: begin
            miss_ready_o = 1'b1;
            if (miss_valid_i) state_d = REQ;
         end
         REQ: begin
            mem_ar_valid_o = 1'b1;
            mem_ar_addr_o  = ar_addr;
            mem_ar_len_o   = 8'(NB-1);
            mem_ar_burst_o = BURST;
            if (mem_ar_ready_i) state_d = FILL;
         end
         FILL: begin
            mem_r_ready_o = 1'b1;
            if (mem_r_valid_i && last_beat) state_d = TAG;
         end
         TAG: begin
            tag_wr_o      = 1'b1;
            tag_index_o   = idx;
            tag_o         = line_q[IDX_W +: TAG_W];
            tag_valid_o   = !err_q;
            refill_done_o = 1'b1;
            refill_err_o  = err_q;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: vector table, hand sequences, random refills.
`timescale 1ns/1ps
module tb_icache_refill;

`ifdef ICACHE_REFILL_CWF_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        miss_valid;
   logic [31:0] miss_addr;
   logic        miss_ready_o;
   logic        mem_ar_valid_o;
   logic        mem_ar_ready;
   logic [31:0] mem_ar_addr_o;
   logic [7:0]  mem_ar_len_o;
   logic [1:0]  mem_ar_burst_o;
   logic        mem_r_valid;
   logic        mem_r_ready_o;
   logic [63:0] mem_r_data;
   logic [1:0]  mem_r_resp;
   logic        mem_r_last;
   logic [9:0]  ram_addr_o;
   logic [63:0] ram_data_o;
   logic        ram_wr_o;
   logic        tag_wr_o;
   logic [7:0]  tag_index_o;
   logic [18:0] tag_o;
   logic        tag_valid_o;
   logic        refill_done_o;
   logic        refill_err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   icache_refill dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .miss_valid_i   (miss_valid),
      .miss_addr_i    (miss_addr),
      .miss_ready_o   (miss_ready_o),
      .mem_ar_valid_o (mem_ar_valid_o),
      .mem_ar_ready_i (mem_ar_ready),
      .mem_ar_addr_o  (mem_ar_addr_o),
      .mem_ar_len_o   (mem_ar_len_o),
      .mem_ar_burst_o (mem_ar_burst_o),
      .mem_r_valid_i  (mem_r_valid),
      .mem_r_ready_o  (mem_r_ready_o),
      .mem_r_data_i   (mem_r_data),
      .mem_r_resp_i   (mem_r_resp),
      .mem_r_last_i   (mem_r_last),
      .ram_addr_o     (ram_addr_o),
      .ram_data_o     (ram_data_o),
      .ram_wr_o       (ram_wr_o),
      .tag_wr_o       (tag_wr_o),
      .tag_index_o    (tag_index_o),
      .tag_o          (tag_o),
      .tag_valid_o    (tag_valid_o),
      .refill_done_o  (refill_done_o),
      .refill_err_o   (refill_err_o)
   );

   typedef struct {
      logic [31:0] addr;
      int          dly;
      int          gap;
      int          eb;
      int          lb;
      bit          keep;
      logic [31:0] exp_ar;
      bit          exp_tv;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", nm, got, exp);
      end
   endtask

   task automatic chk_idle_outs(input string nm);
      logic any;
      any = mem_ar_valid_o | (|mem_ar_addr_o) | (|mem_ar_len_o)
          | (|mem_ar_burst_o) | mem_r_ready_o | (|ram_addr_o)
          | (|ram_data_o) | ram_wr_o | tag_wr_o | (|tag_index_o)
          | (|tag_o) | tag_valid_o | refill_done_o | refill_err_o;
      chk({nm, "_outs_zero"}, 64'(any), 64'd0);
      chk({nm, "_ready"}, 64'(miss_ready_o), 64'd1);
   endtask

   // Model: line/beat arithmetic straight from the address rules.
   function automatic logic [31:0] model_ar(input logic [31:0] a);
      return CWF ? (a & ~32'h7) : (a & ~32'h1f);
   endfunction

   task automatic do_refill(input logic [31:0] a, input int dly,
                            input int gap, input int eb, input int lb,
                            input bit keep, input logic [31:0] exp_ar,
                            input bit exp_tv);
      logic [63:0] dat [4];
      logic [9:0]  w_addr [$];
      logic [63:0] w_data [$];
      int sent, arw, done_n, done_cyc, cyc, start, nerr_alone;
      bit fin, early_rdy;
      logic [7:0]  t_idx;
      logic [18:0] t_tag;
      logic t_v, t_e;
      logic [31:0] idx;
      sent = 0; arw = 0; done_n = 0; done_cyc = 0; cyc = 0;
      nerr_alone = 0; fin = 0; early_rdy = 0;
      t_idx = '0; t_tag = '0; t_v = 0; t_e = 0;
      for (int j = 0; j < 4; j++) dat[j] = {$urandom, $urandom};
      start = CWF ? int'((a >> 3) & 32'h3) : 0;
      idx = (a >> 5) & 32'hff;
      miss_addr = a;
      miss_valid = 1'b1;
      chk("miss_ready_idle", 64'(miss_ready_o), 64'd1);
      @(negedge clk);
      if (!keep) miss_valid = 1'b0;
      while (!fin && cyc < 300) begin
         cyc++;
         if (ram_wr_o) begin
            w_addr.push_back(ram_addr_o);
            w_data.push_back(ram_data_o);
         end
         if (mem_ar_valid_o) begin
            chk("ar_addr", 64'(mem_ar_addr_o), 64'(exp_ar));
            chk("ar_len", 64'(mem_ar_len_o), 64'd3);
            chk("ar_burst", 64'(mem_ar_burst_o), CWF ? 64'd2 : 64'd1);
         end
         if (refill_err_o && !refill_done_o) nerr_alone++;
         if (refill_done_o) begin
            done_n++;
            if (done_n == 1) begin
               done_cyc = cyc;
               t_idx = tag_index_o; t_tag = tag_o;
               t_v = tag_valid_o; t_e = refill_err_o;
               chk("tag_wr_with_done", 64'(tag_wr_o), 64'd1);
            end
         end
         if (done_n > 0 && cyc == done_cyc + 1) begin
            chk("ready_after_tag", 64'(miss_ready_o), 64'd1);
            fin = 1;
         end else if (miss_ready_o) begin
            early_rdy = 1;
         end
         mem_r_valid = 1'b0;
         mem_ar_ready = 1'b0;
         if (!fin) begin
            if (mem_ar_valid_o) begin
               mem_ar_ready = (arw >= dly);
               arw++;
            end
            if (mem_r_ready_o && sent < 4 && (gap == 0 || cyc % 2 == 0)) begin
               mem_r_valid = 1'b1;
               mem_r_data = dat[sent];
               mem_r_resp = (sent == eb) ? 2'b10 : 2'b00;
               mem_r_last = (sent == 3) ^ (sent == lb);
               sent++;
            end
            @(negedge clk);
         end
      end
      if (!fin) chk("refill_timeout", 64'd0, 64'd1);
      chk("done_once", 64'(done_n), 64'd1);
      chk("n_ram_writes", 64'(w_addr.size()), 64'd4);
      for (int j = 0; j < 4 && j < w_addr.size(); j++) begin
         chk("ram_addr", 64'(w_addr[j]), 64'(idx * 4 + (start + j) % 4));
         chk("ram_data", w_data[j], dat[j]);
      end
      chk("tag_index", 64'(t_idx), 64'(idx));
      chk("tag", 64'(t_tag), 64'(a >> 13));
      chk("tag_valid", 64'(t_v), 64'(exp_tv));
      chk("refill_err", 64'(t_e), 64'(!exp_tv));
      chk("err_without_done", 64'(nerr_alone), 64'd0);
      chk("early_miss_ready", 64'(early_rdy), 64'd0);
      if (dly == 0 && gap == 0) chk("latency", 64'(done_cyc), 64'd6);
   endtask

   vec_t vecs [6];

   initial begin
      int nbad;
      vecs[0] = '{32'h0000_1234, 0, 0, -1, -1, 1'b0,
                  CWF ? 32'h0000_1230 : 32'h0000_1220, 1'b1};
      vecs[1] = '{32'h0000_1234, 5, 1, -1, -1, 1'b0,
                  CWF ? 32'h0000_1230 : 32'h0000_1220, 1'b1};
      vecs[2] = '{32'hDEAD_BEEF, 0, 0,  2, -1, 1'b0,
                  CWF ? 32'hDEAD_BEE8 : 32'hDEAD_BEE0, 1'b0};
      vecs[3] = '{32'hFFFF_FFFC, 1, 0, -1,  1, 1'b1,
                  CWF ? 32'hFFFF_FFF8 : 32'hFFFF_FFE0, 1'b0};
      vecs[4] = '{32'h0000_0008, 0, 0, -1,  3, 1'b0,
                  CWF ? 32'h0000_0008 : 32'h0000_0000, 1'b0};
      vecs[5] = '{32'h8000_0010, 2, 0, -1, -1, 1'b0,
                  CWF ? 32'h8000_0010 : 32'h8000_0000, 1'b1};

      rst_ni = 1'b0;
      miss_valid = 1'b0; miss_addr = '0;
      mem_ar_ready = 1'b0; mem_r_valid = 1'b0;
      mem_r_data = '0; mem_r_resp = '0; mem_r_last = 1'b0;
      #1;
      chk_idle_outs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      chk_idle_outs("post_reset");

      for (int i = 0; i < 6; i++)
         do_refill(vecs[i].addr, vecs[i].dly, vecs[i].gap, vecs[i].eb,
                   vecs[i].lb, vecs[i].keep, vecs[i].exp_ar, vecs[i].exp_tv);

      // Abort mid-burst with async reset after beat 1 is accepted.
      miss_valid = 1'b1; miss_addr = 32'h0000_4560;
      @(negedge clk);
      miss_valid = 1'b0;
      mem_ar_ready = 1'b1;
      @(negedge clk);
      mem_ar_ready = 1'b0;
      mem_r_valid = 1'b1; mem_r_data = 64'h1111; mem_r_resp = 2'b00;
      mem_r_last = 1'b0;
      @(negedge clk);
      mem_r_data = 64'h2222;
      @(negedge clk);
      mem_r_valid = 1'b0;
      chk("pre_abort_ram_wr", 64'(ram_wr_o), 64'd1);
      #2 rst_ni = 1'b0;
      #1 chk_idle_outs("abort");
      @(negedge clk);
      rst_ni = 1'b1;
      nbad = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (tag_wr_o || ram_wr_o || refill_done_o || !miss_ready_o) nbad++;
      end
      chk("abort_no_tag", 64'(nbad), 64'd0);
      do_refill(32'h0000_1234, 0, 0, -1, -1, 1'b0, model_ar(32'h0000_1234), 1'b1);

      for (int i = 0; i < 20; i++) begin
         logic [31:0] a;
         int r1, r2, eb, lb;
         a  = $urandom;
         r1 = $urandom_range(0, 15);
         r2 = $urandom_range(0, 15);
         eb = (r1 < 4) ? r1 : -1;
         lb = (r2 < 4) ? r2 : -1;
         do_refill(a, $urandom_range(0, 3), $urandom_range(0, 1), eb, lb,
                   1'($urandom_range(0, 1)), model_ar(a),
                   (eb < 0) && (lb < 0));
      end
      miss_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
